// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed N-digit 7-segment display controller.
// A value is captured on a load strobe and shown in hex, or in decimal after a
// bit-serial double-dabble conversion. The block also provides leading-zero
// blanking, per-digit decimal points, 16-step brightness and an overflow
// indication (all digits show '-').
module seg7_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int DATA_W    = 12,
    parameter int TICK_LOG2 = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [DATA_W-1:0]   value_i,
    input  logic                load_i,
    input  logic                dec_mode_i,
    input  logic                lz_blank_i,
    input  logic [N_DIGITS-1:0] dp_i,
    input  logic [3:0]          bright_i,
    output logic [N_DIGITS-1:0] an_o,
    output logic [6:0]          seg_o,
    output logic                dp_n_o,
    output logic                busy_o,
    output logic                ovf_o
);

    localparam int DISP_W = 4 * N_DIGITS;
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [63:0] DEC_MAX = 64'(10 ** N_DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DISP_W-1:0]   bcd_q, bcd_d;
    logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic [N_DIGITS-1:0] dp_lat_q, dp_lat_d;
    logic [N_DIGITS-1:0] dp_show_q, dp_show_d;
    logic                ovf_q, ovf_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [TICK_LOG2-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dpn_q, dpn_d;

    logic [63:0]         value_ext;
    logic [DISP_W-1:0]   adj;
    logic [3:0]          digit;
    logic [DISP_W-1:0]   upper;
    logic                blank;

    assign value_ext = 64'(value_i);

    // Double-dabble correction: every BCD nibble of 5 or more gets 3 added
    // so that the following left shift carries correctly into the next digit.
    function automatic logic [DISP_W-1:0] add3(input logic [DISP_W-1:0] b);
        logic [DISP_W-1:0] r;
        r = b;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (b[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = b[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Active-high glyphs, bit 0 = segment a .. bit 6 = segment g.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Load/convert FSM: hex loads go straight to the display register, decimal
    // loads run DATA_W shift steps and then publish the whole BCD word at once.
    // Overflow is judged on the captured value so truncated BCD never matters.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        bitcnt_d   = bitcnt_q;
        disp_d     = disp_q;
        dp_lat_d   = dp_lat_q;
        dp_show_d  = dp_show_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
        adj        = add3(bcd_q);
        case (state_q)
            IDLE: begin
                if (load_i && !busy_q) begin
                    dp_lat_d = dp_i;
                    if (dec_mode_i) begin
                        shift_d    = value_i;
                        bcd_d      = '0;
                        bitcnt_d   = '0;
                        busy_d     = 1'b1;
                        ovf_pend_d = (value_ext > DEC_MAX);
                        state_d    = SHIFT;
                    end else begin
                        disp_d    = value_ext[DISP_W-1:0];
                        dp_show_d = dp_i;
                        ovf_d     = ((value_ext >> DISP_W) != 64'd0);
                    end
                end
            end
            SHIFT: begin
                bcd_d    = DISP_W'({adj, shift_q[DATA_W-1]});
                shift_d  = shift_q << 1;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_d    = bcd_q;
                dp_show_d = dp_lat_q;
                ovf_d     = ovf_pend_q;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scan timing and pin drive: the tick counter paces the digit index, and the
    // anode/segment/dp values for the current slot are computed for the next edge.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (&cnt_q) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        digit = disp_q[4*idx_q +: 4];
        upper = disp_q >> (4 * idx_q);
        blank = lz_blank_i && (idx_q != '0) && (upper == '0);
        an_d  = '1;
        if (cnt_q[TICK_LOG2-1 -: 4] <= bright_i) begin
            an_d[idx_q] = 1'b0;
        end
        if (ovf_q) begin
            seg_d = 7'h3F;
            dpn_d = 1'b1;
        end else if (blank) begin
            seg_d = 7'h7F;
            dpn_d = ~dp_show_q[idx_q];
        end else begin
            seg_d = ~glyph(digit);
            dpn_d = ~dp_show_q[idx_q];
        end
    end

    // All state registers; reset leaves the display dark and the FSM idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            bcd_q      <= '0;
            bitcnt_q   <= '0;
            disp_q     <= '0;
            dp_lat_q   <= '0;
            dp_show_q  <= '0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= '1;
            dpn_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            bitcnt_q   <= bitcnt_d;
            disp_q     <= disp_d;
            dp_lat_q   <= dp_lat_d;
            dp_show_q  <= dp_show_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dpn_q      <= dpn_d;
        end
    end

    assign an_o   = an_q;
    assign seg_o  = seg_q;
    assign dp_n_o = dpn_q;
    assign busy_o = busy_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (4 digits/12 bits and 3 digits/14 bits)
// share one stimulus stream; a time-based display model predicts every pin each cycle.
module tb_seg7_scan_ctrl;

    localparam int T_LOG2 = 4;
    localparam int SLOT   = 1 << T_LOG2;

    logic        clk = 1'b0;
    logic        rstN;
    logic [13:0] value;
    logic        load;
    logic        decMode;
    logic        lzBlank;
    logic [7:0]  dp;
    logic [3:0]  bright;

    logic [3:0]  an0;
    logic [6:0]  seg0;
    logic        dpn0, busy0, ovf0;
    logic [2:0]  an1;
    logic [6:0]  seg1;
    logic        dpn1, busy1, ovf1;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 1'b0;

    // Model state, one slot per instance
    int          nDig  [2] = '{4, 3};
    int          dataW [2] = '{12, 14};
    longint      mVal  [2];
    bit          mDec  [2];
    bit          mOvf  [2];
    bit          mBusy [2];
    logic [7:0]  mDp   [2];
    longint      pendVal [2];
    logic [7:0]  pendDp  [2];
    int          countdown [2];
    logic [7:0]  expAn  [2];
    logic [6:0]  expSeg [2];
    logic        expDpn [2];
    int          tEdge;

    logic [6:0] glyphLit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.N_DIGITS(4), .DATA_W(12), .TICK_LOG2(T_LOG2)) dut0 (
        .clk_i(clk), .rst_ni(rstN), .value_i(value[11:0]), .load_i(load),
        .dec_mode_i(decMode), .lz_blank_i(lzBlank), .dp_i(dp[3:0]), .bright_i(bright),
        .an_o(an0), .seg_o(seg0), .dp_n_o(dpn0), .busy_o(busy0), .ovf_o(ovf0)
    );

    seg7_scan_ctrl #(.N_DIGITS(3), .DATA_W(14), .TICK_LOG2(T_LOG2)) dut1 (
        .clk_i(clk), .rst_ni(rstN), .value_i(value), .load_i(load),
        .dec_mode_i(decMode), .lz_blank_i(lzBlank), .dp_i(dp[2:0]), .bright_i(bright),
        .an_o(an1), .seg_o(seg1), .dp_n_o(dpn1), .busy_o(busy1), .ovf_o(ovf1)
    );

    function automatic longint lpow(input int b, input int e);
        longint r = 1;
        for (int k = 0; k < e; k++) r = r * b;
        return r;
    endfunction

    // Pins for the slot that is current before this edge, from the shown number.
    task automatic modelOutputs(input int u);
        int n, c, i, base;
        longint place;
        logic [3:0] d;
        bit blank;
        n     = nDig[u];
        c     = tEdge % SLOT;
        i     = (tEdge / SLOT) % n;
        base  = mDec[u] ? 10 : 16;
        place = lpow(base, i);
        expAn[u] = 8'((1 << n) - 1);
        if ((c >> (T_LOG2 - 4)) <= int'(bright)) expAn[u][i] = 1'b0;
        if (mOvf[u]) begin
            expSeg[u] = 7'h3F;
            expDpn[u] = 1'b1;
        end else begin
            d = 4'((mVal[u] / place) % base);
            blank = lzBlank && (i > 0) && (mVal[u] < place);
            expSeg[u] = blank ? 7'h7F : ~glyphLit[d];
            expDpn[u] = ~mDp[u][i];
        end
    endtask

    // Load acceptance and the delayed arrival of decimal results.
    task automatic modelLoad(input int u);
        longint v;
        v = longint'(value) & (lpow(2, dataW[u]) - 1);
        if (mBusy[u]) begin
            countdown[u]--;
            if (countdown[u] == 0) begin
                mVal[u]  = pendVal[u];
                mDec[u]  = 1'b1;
                mOvf[u]  = pendVal[u] > lpow(10, nDig[u]) - 1;
                mDp[u]   = pendDp[u];
                mBusy[u] = 1'b0;
            end
        end else if (load) begin
            if (!decMode) begin
                mVal[u] = v;
                mDec[u] = 1'b0;
                mOvf[u] = v >= lpow(16, nDig[u]);
                mDp[u]  = dp;
            end else begin
                pendVal[u]   = v;
                pendDp[u]    = dp;
                countdown[u] = dataW[u] + 1;
                mBusy[u]     = 1'b1;
            end
        end
    endtask

    // Model advances on the same edges as the DUT and clears on reset.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tEdge = 0;
            for (int u = 0; u < 2; u++) begin
                mVal[u] = 0; mDec[u] = 1'b0; mOvf[u] = 1'b0; mBusy[u] = 1'b0;
                mDp[u] = 8'h00; countdown[u] = 0;
                expAn[u] = 8'((1 << nDig[u]) - 1);
                expSeg[u] = 7'h7F;
                expDpn[u] = 1'b1;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                modelOutputs(u);
                modelLoad(u);
            end
            tEdge++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("pins0", {14'd0, busy0, ovf0, dpn0, seg0, 4'd0, an0},
                        {14'd0, mBusy[0], mOvf[0], expDpn[0], expSeg[0], expAn[0]});
            checkOutput("pins1", {14'd0, busy1, ovf1, dpn1, seg1, 5'd0, an1},
                        {14'd0, mBusy[1], mOvf[1], expDpn[1], expSeg[1], expAn[1]});
        end
    end

    // One-cycle load strobe sampled on exactly one rising edge.
    task automatic applyStimulus(input logic [13:0] v, input logic dec, input logic [7:0] dps);
        @(posedge clk); #1;
        value = v; decMode = dec; dp = dps; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDigit(input int u, input int k, output bit ok);
        logic [3:0] want0;
        logic [2:0] want1;
        want0 = ~(4'b0001 << k);
        want1 = ~(3'b001 << k);
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (u == 0) ok = (an0 == want0);
            else        ok = (an1 == want1);
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL waitDigit u%0d k%0d: an0=%b an1=%b, required digit lit within 300 cycles", u, k, an0, an1);
        end
    endtask

    initial begin
        bit ok;
        int cnt0, cnt1, multi;
        rstN = 1'b0; value = '0; load = 1'b0; decMode = 1'b0; lzBlank = 1'b0;
        dp = 8'h00; bright = 4'hF;

        // T1 reset
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("resetAn", 32'(an0), 32'h0000_000F);
        checkOutput("resetSeg", 32'(seg0), 32'h0000_007F);
        checkOutput("resetBusy", 32'(busy0), 32'h0);
        @(posedge clk); #1 rstN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("firstAn", 32'(an0), 32'h0000_000E);
        checkOutput("firstSeg", 32'(seg0), 32'h0000_0040);

        // T2 hex with blanking and a decimal point on digit 1
        lzBlank = 1'b1;
        applyStimulus(14'h1A5C, 1'b0, 8'h02);
        settle(2);
        waitDigit(0, 0, ok); if (ok) checkOutput("hexDig0", 32'(seg0), 32'h0000_0046);
        waitDigit(0, 1, ok); if (ok) checkOutput("hexDp1", 32'(dpn0), 32'h0);
        waitDigit(0, 2, ok); if (ok) checkOutput("hexDig2", 32'(seg0), 32'h0000_0008);
        waitDigit(0, 3, ok); if (ok) checkOutput("hexBlank3", 32'(seg0), 32'h0000_007F);
        waitDigit(1, 0, ok); if (ok) checkOutput("hexOvfSeg1", 32'(seg1), 32'h0000_003F);
        checkOutput("hexOvf1", 32'(ovf1), 32'h1);

        // T3 decimal 4095 with busy length
        applyStimulus(14'd4095, 1'b1, 8'h00);
        cnt0 = 0; cnt1 = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy0) cnt0++;
            if (busy1) cnt1++;
        end
        checkOutput("busyLen0", 32'(cnt0), 32'd13);
        checkOutput("busyLen1", 32'(cnt1), 32'd15);
        waitDigit(0, 0, ok); if (ok) checkOutput("decDig0", 32'(seg0), 32'h0000_0012);
        waitDigit(0, 3, ok); if (ok) checkOutput("decDig3", 32'(seg0), 32'h0000_0019);
        checkOutput("decOvf0", 32'(ovf0), 32'h0);
        checkOutput("decOvf1", 32'(ovf1), 32'h1);

        // T4 overflow, load during busy ignored, then overflow clears
        applyStimulus(14'd1000, 1'b1, 8'h00);
        settle(2);
        applyStimulus(14'h0123, 1'b0, 8'h00);
        settle(20);
        waitDigit(0, 0, ok); if (ok) checkOutput("kDig0", 32'(seg0), 32'h0000_0040);
        waitDigit(0, 1, ok); if (ok) checkOutput("kDig1", 32'(seg0), 32'h0000_0040);
        waitDigit(0, 3, ok); if (ok) checkOutput("kDig3", 32'(seg0), 32'h0000_0079);
        waitDigit(1, 2, ok); if (ok) checkOutput("kDash1", 32'(seg1), 32'h0000_003F);
        checkOutput("kOvf1", 32'(ovf1), 32'h1);
        applyStimulus(14'd999, 1'b1, 8'h00);
        settle(20);
        checkOutput("clrOvf1", 32'(ovf1), 32'h0);
        waitDigit(1, 2, ok); if (ok) checkOutput("nineDig2", 32'(seg1), 32'h0000_0010);

        // T5 brightness
        bright = 4'h0;
        settle(2);
        cnt0 = 0; multi = 0;
        for (int n = 0; n < 4 * SLOT; n++) begin
            @(negedge clk);
            if (an0 != 4'hF) cnt0++;
            if ($countones(~an0) > 1) multi++;
        end
        checkOutput("dimLit", 32'(cnt0), 32'd4);
        checkOutput("dimMulti", 32'(multi), 32'd0);
        bright = 4'hF;
        settle(2);
        cnt0 = 0;
        for (int n = 0; n < 4 * SLOT; n++) begin
            @(negedge clk);
            if (an0 != 4'hF) cnt0++;
        end
        checkOutput("fullLit", 32'(cnt0), 32'd64);

        // T6 reset during conversion, then a fresh decimal load
        applyStimulus(14'd4095, 1'b1, 8'h00);
        settle(5);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midRstBusy", 32'(busy0), 32'h0);
        checkOutput("midRstAn", 32'(an0), 32'h0000_000F);
        settle(2);
        rstN = 1'b1;
        settle(2);
        checkOutput("postRstBusy", 32'(busy0), 32'h0);
        waitDigit(0, 0, ok); if (ok) checkOutput("postRstDig0", 32'(seg0), 32'h0000_0040);
        waitDigit(0, 1, ok); if (ok) checkOutput("postRstBlank1", 32'(seg0), 32'h0000_007F);
        applyStimulus(14'd7, 1'b1, 8'h00);
        settle(20);
        waitDigit(0, 0, ok); if (ok) checkOutput("sevenDig0", 32'(seg0), 32'h0000_0078);
        waitDigit(0, 1, ok); if (ok) checkOutput("sevenBlank1", 32'(seg0), 32'h0000_007F);

        settle(2);
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
